// File: rtl/serializer.sv
// serializer: parallel-to-serial converter, MSB first.
//
// Accepts a DATA_BUS_WIDTH-bit word when idle and shifts out its N most
// significant bits, one per clock, starting the cycle after acceptance.
// N is data_mod_i, or DATA_BUS_WIDTH when data_mod_i is zero.
//
// Ports:
//   clk_i          - clock, all state updates on the rising edge
//   srst_i         - asynchronous active-high reset
//   data_i         - parallel word, bit DATA_BUS_WIDTH-1 goes out first
//   data_mod_i     - number of MSBs to send (0 = full width)
//   data_val_i     - request strobe for data_i/data_mod_i
//   ser_data_o     - serial bit (0 whenever ser_data_val_o is 0)
//   ser_data_val_o - ser_data_o carries a valid bit
//   busy_o         - a word is in flight; requests are ignored
module serializer #(
  parameter int unsigned DATA_BUS_WIDTH = 16,
  parameter int unsigned MOD_WIDTH      = $clog2(DATA_BUS_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [DATA_BUS_WIDTH-1:0] data_i,
  input  logic [MOD_WIDTH-1:0]      data_mod_i,
  input  logic                      data_val_i,
  output logic                      ser_data_o,
  output logic                      ser_data_val_o,
  output logic                      busy_o
);

  // One extra counter bit so a full-width word (N = DATA_BUS_WIDTH) fits.
  localparam int unsigned CNT_W = MOD_WIDTH + 1;

  if (DATA_BUS_WIDTH < 4 || (DATA_BUS_WIDTH & (DATA_BUS_WIDTH - 1)) != 0) begin : g_bad_width
    $error("serializer: DATA_BUS_WIDTH must be a power of two, at least 4");
  end

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [DATA_BUS_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          load_cnt;
  logic                      accept;
  logic                      last_bit;

  always_comb begin
    load_cnt = (data_mod_i == '0) ? CNT_W'(DATA_BUS_WIDTH) : {1'b0, data_mod_i};
    accept   = (state == IDLE) && data_val_i;
    last_bit = (cnt == CNT_W'(1));
  end

  // State register
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (data_val_i) state_next = SHIFT;
      SHIFT:   if (last_bit)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: the MSB of shift_reg is always the bit on the wire in SHIFT.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      shift_reg <= '0;
      cnt       <= '0;
    end else if (accept) begin
      shift_reg <= data_i;
      cnt       <= load_cnt;
    end else if (state == SHIFT) begin
      shift_reg <= {shift_reg[DATA_BUS_WIDTH-2:0], 1'b0};
      cnt       <= cnt - CNT_W'(1);
    end
  end

  // Outputs decode purely from state, so reset clears them immediately.
  always_comb begin
    ser_data_val_o = (state == SHIFT);
    busy_o         = (state == SHIFT);
    ser_data_o     = (state == SHIFT) && shift_reg[DATA_BUS_WIDTH-1];
  end

endmodule

// File: tb/tb_serializer.sv
// tb_serializer: self-checking bench for serializer (DATA_BUS_WIDTH = 16).
// Table-driven directed words, hand sequences for busy/reset corners,
// random traffic against a bit-queue model, and a full-width loopback.
module tb_serializer;

  localparam int unsigned W = 16;

  logic          clk_i = 1'b0;
  logic          srst_i;
  logic [W-1:0]  data_i;
  logic [3:0]    data_mod_i;
  logic          data_val_i;
  logic          ser_data_o;
  logic          ser_data_val_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  serializer #(.DATA_BUS_WIDTH(W)) dut (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .data_val_i     (data_val_i),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] data;
    logic [3:0]   mod;
    int           n;
    logic [W-1:0] exp_bits;  // expected stream, first bit in [W-1]
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_val"},  {31'b0, ser_data_val_o}, 32'd0);
    chk({name, "_busy"}, {31'b0, busy_o},         32'd0);
    chk({name, "_bit"},  {31'b0, ser_data_o},     32'd0);
  endtask

  // Called just after a negedge: request is taken on the following posedge.
  task automatic send(input logic [W-1:0] d, input logic [3:0] m);
    data_i     = d;
    data_mod_i = m;
    data_val_i = 1'b1;
    @(negedge clk_i);
    data_val_i = 1'b0;
  endtask

  // Called at the negedge inside the first bit cycle.
  task automatic expect_stream(input string name, input logic [W-1:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      chk({name, "_val"},  {31'b0, ser_data_val_o}, 32'd1);
      chk({name, "_busy"}, {31'b0, busy_o},         32'd1);
      chk({name, "_bit"},  {31'b0, ser_data_o},     {31'b0, bits[W-1-i]});
      @(negedge clk_i);
    end
    chk_idle({name, "_end"});
  endtask

  initial begin
    bit           q[$];
    logic [W-1:0] sent[$];
    logic [W-1:0] acc;
    logic [W-1:0] w;
    int           n;
    int           rem;
    int           nb;
    int           got;
    int           cyc;
    logic         ev;

    vecs[0] = '{16'hA5C3, 4'd0,  16, 16'b1010_0101_1100_0011};
    vecs[1] = '{16'hF000, 4'd3,   3, 16'b1110_0000_0000_0000};
    vecs[2] = '{16'h8001, 4'd1,   1, 16'b1000_0000_0000_0000};
    vecs[3] = '{16'h1234, 4'd4,   4, 16'b0001_0000_0000_0000};
    vecs[4] = '{16'hFFFF, 4'd15, 15, 16'b1111_1111_1111_1110};
    vecs[5] = '{16'h0001, 4'd0,  16, 16'b0000_0000_0000_0001};
    vecs[6] = '{16'h4000, 4'd2,   2, 16'b0100_0000_0000_0000};

    srst_i     = 1'b1;
    data_i     = '0;
    data_mod_i = '0;
    data_val_i = 1'b0;
    #3;
    chk_idle("reset");
    @(negedge clk_i);
    srst_i = 1'b0;
    @(negedge clk_i);
    chk_idle("post_reset");

    // Directed table
    for (int v = 0; v < 7; v++) begin
      send(vecs[v].data, vecs[v].mod);
      expect_stream($sformatf("vec%0d", v), vecs[v].exp_bits, vecs[v].n);
    end

    // Requests and data changes while busy must not disturb the word
    send(16'hA5C3, 4'd0);
    for (int i = 0; i < 16; i++) begin
      w = 16'hA5C3;
      chk("busy_ign_bit", {31'b0, ser_data_o}, {31'b0, w[15-i]});
      chk("busy_ign_val", {31'b0, ser_data_val_o}, 32'd1);
      data_i     = 16'h0F0F ^ 16'(i);
      data_mod_i = 4'(i);
      data_val_i = (i % 4 == 1);
      @(negedge clk_i);
    end
    data_val_i = 1'b0;
    chk_idle("busy_ign_end");
    @(negedge clk_i);
    chk_idle("busy_ign_end2");

    // Held request with alternating words: burst, one idle cycle, burst
    data_i     = 16'hFFFF;
    data_mod_i = 4'd0;
    data_val_i = 1'b1;
    @(negedge clk_i);
    data_i = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      chk("held_a_val", {31'b0, ser_data_val_o}, 32'd1);
      chk("held_a_bit", {31'b0, ser_data_o},     32'd1);
      @(negedge clk_i);
    end
    chk_idle("held_gap");
    @(negedge clk_i);
    data_val_i = 1'b0;
    expect_stream("held_b", 16'h0000, 16);

    // Asynchronous reset during the 8th bit, then an intact word
    send(16'hA5C3, 4'd0);
    for (int i = 0; i < 7; i++) @(negedge clk_i);
    chk("rst_bit8_val", {31'b0, ser_data_val_o}, 32'd1);
    chk("rst_bit8",     {31'b0, ser_data_o},     32'd1);
    #2 srst_i = 1'b1;
    #1;
    chk_idle("rst_async");
    @(negedge clk_i);
    srst_i = 1'b0;
    @(negedge clk_i);
    chk_idle("rst_abort");
    send(16'h8001, 4'd0);
    expect_stream("rst_after", 16'h8001, 16);

    // Request ignored under reset, taken on the first edge after release
    srst_i     = 1'b1;
    data_i     = 16'hC000;
    data_mod_i = 4'd2;
    data_val_i = 1'b1;
    @(negedge clk_i);
    chk("rst_req_ign", {31'b0, ser_data_val_o}, 32'd0);
    srst_i = 1'b0;
    @(negedge clk_i);
    data_val_i = 1'b0;
    expect_stream("rst_first", 16'hC000, 2);

    // Random traffic against a bit-queue model
    q.delete();
    for (int c = 0; c < 2000; c++) begin
      data_i     = W'($urandom);
      data_mod_i = 4'($urandom);
      data_val_i = ($urandom_range(2) != 0);
      @(posedge clk_i);
      if (q.size() > 0) begin
        void'(q.pop_front());
      end else if (data_val_i) begin
        n = (data_mod_i == 0) ? W : int'(data_mod_i);
        for (int i = 0; i < n; i++) q.push_back(data_i[W-1-i]);
      end
      @(negedge clk_i);
      ev = (q.size() > 0);
      chk("rand_val",  {31'b0, ser_data_val_o}, {31'b0, ev});
      chk("rand_busy", {31'b0, busy_o},         {31'b0, ev});
      chk("rand_bit",  {31'b0, ser_data_o},     {31'b0, ev ? q[0] : 1'b0});
    end
    data_val_i = 1'b0;
    repeat (20) @(negedge clk_i);
    chk_idle("rand_drain");

    // Loopback through a 16-bit deserializer, request held high
    rem = 0; nb = 0; got = 0; cyc = 0; acc = '0;
    data_mod_i = 4'd0;
    data_val_i = 1'b1;
    while (got < 1000 && cyc < 40000) begin
      data_i = W'($urandom);
      @(posedge clk_i);
      if (rem > 0) rem--;
      else begin
        sent.push_back(data_i);
        rem = 16;
      end
      @(negedge clk_i);
      cyc++;
      if (ser_data_val_o) begin
        acc = {acc[W-2:0], ser_data_o};
        nb++;
        if (nb == 16) begin
          if (sent.size() > 0) chk("loopback_word", {16'b0, acc}, {16'b0, sent.pop_front()});
          else chk("loopback_extra", {16'b0, acc}, 32'hFFFF_FFFF);
          nb = 0;
          got++;
        end
      end
    end
    data_val_i = 1'b0;
    chk("loopback_count", got, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
